// File: rtl/ehgu_fifo_wr_ctrl_if.sv
// Producer-side valid/ready handshake into the ehgu FIFO write controller.
// The producer holds master; the write controller holds slave.
interface ehgu_fifo_wr_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             din_ready;

    modport master (
        output din_valid,
        output din,
        input  din_ready
    );

    modport slave (
        input  din_valid,
        input  din,
        output din_ready
    );
endinterface

// File: rtl/ehgu_fifo_wr_ctrl.sv
// ehgu async FIFO write side: write pointer (bin/Gray), read-pointer sync, level/full/overflow.
// Accepted writes hit memory and the pointers at the same edge; din_ready drops combinationally when full or disabled.
module ehgu_fifo_wr_ctrl #(
    parameter int WIDTH        = 8,
    parameter int AWIDTH       = 8,
    parameter int DEPTH        = 2**AWIDTH,
    parameter int SYNC_STG_R2W = 2,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic                 wclk,
    input  logic                 wrstn,
    input  logic                 i_en,
    input  logic                 i_clr_ovf,
    input  logic [AWIDTH:0]      i_rptr_gray,
    ehgu_fifo_wr_ctrl_if.slave   din_if,
    output logic                 o_wenable,
    output logic [AWIDTH-1:0]    o_waddr,
    output logic [WIDTH-1:0]     o_wdata,
    output logic [AWIDTH:0]      o_wptr_gray,
    output logic                 o_full,
    output logic                 o_almost_full,
    output logic [AWIDTH:0]      o_wlevel,
    output logic                 o_overflow
);
    localparam int PW = AWIDTH + 1;

    generate
        if (DEPTH != 2**AWIDTH) begin : g_bad_depth
            $error("ehgu_fifo_wr_ctrl: DEPTH must equal 2**AWIDTH");
        end
        if (SYNC_STG_R2W < 2) begin : g_bad_sync
            $error("ehgu_fifo_wr_ctrl: SYNC_STG_R2W must be at least 2");
        end
        if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
            $error("ehgu_fifo_wr_ctrl: AFULL_THRESH must lie in 1..DEPTH");
        end
    endgenerate

    logic [AWIDTH:0] r_wptr_bin;
    logic [AWIDTH:0] r_wptr_gray;
    logic [AWIDTH:0] r_rptr_sync [SYNC_STG_R2W];
    logic            r_overflow;

    logic [AWIDTH:0] w_wptr_bin_nxt;
    logic [AWIDTH:0] w_rptr_bin_sync;
    logic [AWIDTH:0] w_wlevel;
    logic            w_full;
    logic            w_din_ready;
    logic            w_accept;
    logic            w_write_while_full;

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    always_comb begin
        w_rptr_bin_sync = '0;
        for (int i = AWIDTH; i >= 0; i--) begin
            w_rptr_bin_sync[i] = ^(r_rptr_sync[SYNC_STG_R2W-1] >> i);
        end
    end

    // Read pointer is stale by the sync delay, so the level can only over-report.
    assign w_wlevel           = r_wptr_bin - w_rptr_bin_sync;
    assign w_full             = (w_wlevel == PW'(DEPTH));
    assign w_din_ready        = i_en && !w_full;
    assign w_accept           = din_if.din_valid && w_din_ready;
    assign w_write_while_full = din_if.din_valid && i_en && w_full;
    assign w_wptr_bin_nxt     = r_wptr_bin + 1'b1;

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            for (int i = 0; i < SYNC_STG_R2W; i++) begin
                r_rptr_sync[i] <= '0;
            end
        end else begin
            r_rptr_sync[0] <= i_rptr_gray;
            for (int i = 1; i < SYNC_STG_R2W; i++) begin
                r_rptr_sync[i] <= r_rptr_sync[i-1];
            end
        end
    end

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            r_wptr_bin  <= '0;
            r_wptr_gray <= '0;
        end else if (w_accept) begin
            r_wptr_bin  <= w_wptr_bin_nxt;
            r_wptr_gray <= w_wptr_bin_nxt ^ (w_wptr_bin_nxt >> 1);
        end
    end

    // A set and a clear in the same cycle resolve to set.
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            r_overflow <= 1'b0;
        end else if (w_write_while_full) begin
            r_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign din_if.din_ready = w_din_ready;
    assign o_wenable        = w_accept;
    assign o_waddr          = r_wptr_bin[AWIDTH-1:0];
    assign o_wdata          = din_if.din;
    assign o_wptr_gray      = r_wptr_gray;
    assign o_full           = w_full;
    assign o_almost_full    = (w_wlevel >= PW'(AFULL_THRESH));
    assign o_wlevel         = w_wlevel;
    assign o_overflow       = r_overflow;
endmodule

// File: tb/tb_ehgu_fifo_wr_ctrl.sv
// Bench for ehgu_fifo_wr_ctrl: reset/table vectors, directed fill/release/wrap/enable cases,
// and randomized traffic compared against a write/read counting model.
module tb_ehgu_fifo_wr_ctrl;
    localparam int WIDTH  = 8;
    localparam int AWIDTH = 8;
    localparam int DEPTH  = 256;
    localparam int SYNC   = 2;
    localparam int AFT    = DEPTH - 4;

    logic              wclk = 1'b0;
    logic              wrstn;
    logic              en;
    logic              clr_ovf;
    logic [AWIDTH:0]   rptr_gray;
    logic              wenable;
    logic [AWIDTH-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [AWIDTH:0]   wptr_gray;
    logic              full;
    logic              almost_full;
    logic [AWIDTH:0]   wlevel;
    logic              overflow;

    ehgu_fifo_wr_ctrl_if #(.WIDTH(WIDTH)) din_if ();

    ehgu_fifo_wr_ctrl #(
        .WIDTH        (WIDTH),
        .AWIDTH       (AWIDTH),
        .DEPTH        (DEPTH),
        .SYNC_STG_R2W (SYNC),
        .AFULL_THRESH (AFT)
    ) dut (
        .wclk          (wclk),
        .wrstn         (wrstn),
        .i_en          (en),
        .i_clr_ovf     (clr_ovf),
        .i_rptr_gray   (rptr_gray),
        .din_if        (din_if),
        .o_wenable     (wenable),
        .o_waddr       (waddr),
        .o_wdata       (wdata),
        .o_wptr_gray   (wptr_gray),
        .o_full        (full),
        .o_almost_full (almost_full),
        .o_wlevel      (wlevel),
        .o_overflow    (overflow)
    );

    always #5 wclk = ~wclk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: total writes accepted, total reads the reader has done, and the read
    // count as seen through the synchronizer delay.
    int wr_cnt;
    int rd_cnt;
    int rd_seen;
    int sync_q[$];
    bit ovf_m;

    typedef struct {
        logic              en;
        logic              vld;
        logic [WIDTH-1:0]  din;
        logic              rdy;
        logic              wen;
        logic [AWIDTH-1:0] waddr;
        logic [AWIDTH:0]   lvl;
        logic [AWIDTH:0]   gray;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [AWIDTH:0] gray_of(input int n);
        logic [AWIDTH:0] b;
        b = n[AWIDTH:0];
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        wr_cnt  = 0;
        rd_cnt  = 0;
        rd_seen = 0;
        ovf_m   = 1'b0;
        sync_q.delete();
        repeat (SYNC) sync_q.push_back(0);
    endtask

    // Called on a falling edge; leaves reset on a later falling edge.
    task automatic do_reset();
        wrstn = 1'b0;
        #1;
        chk("rst_async_gray", 32'(wptr_gray), 32'd0);
        chk("rst_async_level", 32'(wlevel), 32'd0);
        @(posedge wclk);
        @(negedge wclk);
        wrstn = 1'b1;
        model_reset();
    endtask

    // One cycle: compare every output with the model, then advance the model at the edge.
    task automatic tick();
        int lvl;
        bit f;
        bit rdy;
        bit wen;
        rptr_gray = gray_of(rd_cnt);
        #1;
        lvl = wr_cnt - rd_seen;
        f   = (lvl == DEPTH);
        rdy = en && !f;
        wen = din_if.din_valid && rdy;
        chk("din_ready",   32'(din_if.din_ready), 32'(rdy));
        chk("wenable",     32'(wenable),          32'(wen));
        chk("waddr",       32'(waddr),            32'(wr_cnt % DEPTH));
        chk("wdata",       32'(wdata),            32'(din_if.din));
        chk("wptr_gray",   32'(wptr_gray),        32'(gray_of(wr_cnt)));
        chk("wlevel",      32'(wlevel),           32'(lvl));
        chk("full",        32'(full),             32'(f));
        chk("almost_full", 32'(almost_full),      32'(lvl >= AFT));
        chk("overflow",    32'(overflow),         32'(ovf_m));
        @(posedge wclk);
        if (wen) wr_cnt++;
        if (din_if.din_valid && en && f) ovf_m = 1'b1;
        else if (clr_ovf)                ovf_m = 1'b0;
        sync_q.push_back(rd_cnt);
        void'(sync_q.pop_front());
        rd_seen = sync_q[0];
        @(negedge wclk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[8];
        logic [AWIDTH:0] prev_g;
        logic [AWIDTH-1:0] prev_a;
        int hist[$];
        int nwrap;
        bit any_full;
        int saved_wr;

        wrstn            = 1'b1;
        en               = 1'b1;
        clr_ovf          = 1'b0;
        rptr_gray        = '0;
        din_if.din_valid = 1'b0;
        din_if.din       = '0;

        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 9'd0, 9'h000};
        tbl[1] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'd0, 9'd0, 9'h000};
        tbl[2] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 8'd0, 9'd0, 9'h000};
        tbl[3] = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 8'd1, 9'd1, 9'h001};
        tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd2, 9'd2, 9'h003};
        tbl[5] = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 8'd2, 9'd2, 9'h003};
        tbl[6] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 8'd2, 9'd2, 9'h003};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd3, 9'd3, 9'h002};

        @(negedge wclk);
        do_reset();

        // Table vectors straight out of reset, read pointer parked at 0.
        for (int i = 0; i < 8; i++) begin
            en               = tbl[i].en;
            din_if.din_valid = tbl[i].vld;
            din_if.din       = tbl[i].din;
            rptr_gray        = '0;
            #1;
            chk("tbl_din_ready", 32'(din_if.din_ready), 32'(tbl[i].rdy));
            chk("tbl_wenable",   32'(wenable),          32'(tbl[i].wen));
            chk("tbl_waddr",     32'(waddr),            32'(tbl[i].waddr));
            chk("tbl_wdata",     32'(wdata),            32'(tbl[i].din));
            chk("tbl_wlevel",    32'(wlevel),           32'(tbl[i].lvl));
            chk("tbl_wptr_gray", 32'(wptr_gray),        32'(tbl[i].gray));
            chk("tbl_full",      32'(full),             32'd0);
            chk("tbl_afull",     32'(almost_full),      32'd0);
            chk("tbl_overflow",  32'(overflow),         32'd0);
            @(posedge wclk);
            @(negedge wclk);
        end

        // Fill from empty with the reader stalled.
        do_reset();
        en = 1'b1;
        din_if.din_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            din_if.din = 8'(i);
            tick();
        end
        #1;
        chk("fill_full",      32'(full),             32'd1);
        chk("fill_din_ready", 32'(din_if.din_ready), 32'd0);
        chk("fill_wlevel",    32'(wlevel),           32'd256);
        chk("fill_overflow",  32'(overflow),         32'd1);
        chk("fill_wptr_gray", 32'(wptr_gray),        32'h180);

        // One read releases full only after the synchronizer delay.
        din_if.din_valid = 1'b0;
        rd_cnt = 1;
        tick();
        chk("rel_edge1_full",  32'(full),   32'd1);
        tick();
        chk("rel_edge2_full",  32'(full),   32'd0);
        chk("rel_edge2_level", 32'(wlevel), 32'd255);
        din_if.din_valid = 1'b1;
        din_if.din       = 8'hC3;
        tick();
        chk("refill_full", 32'(full), 32'd1);

        // Clear racing a write attempt while full, then a clean clear.
        clr_ovf = 1'b1;
        tick();
        chk("clr_vs_set_ovf", 32'(overflow), 32'd1);
        din_if.din_valid = 1'b0;
        tick();
        chk("clr_ovf", 32'(overflow), 32'd0);
        clr_ovf = 1'b0;

        // Disabled while full: no writes, no overflow.
        en = 1'b0;
        din_if.din_valid = 1'b1;
        saved_wr = wr_cnt;
        repeat (10) tick();
        chk("en0_wptr_gray", 32'(wptr_gray), 32'(gray_of(saved_wr)));
        chk("en0_overflow",  32'(overflow),  32'd0);

        // Streaming across two pointer wraps with the reader 3 writes behind.
        do_reset();
        en = 1'b1;
        din_if.din_valid = 1'b1;
        nwrap = 0;
        any_full = 1'b0;
        hist.delete();
        for (int i = 0; i < 600; i++) begin
            din_if.din = 8'($urandom);
            hist.push_back(wr_cnt);
            if (hist.size() > 3) rd_cnt = hist.pop_front();
            prev_g = wptr_gray;
            prev_a = waddr;
            tick();
            if (full) any_full = 1'b1;
            if (prev_a == 8'd255 && waddr == 8'd0) nwrap++;
            chk("wrap_gray_1bit", 32'($countones(prev_g ^ wptr_gray)), 32'd1);
        end
        chk("wrap_count", 32'(nwrap),    32'd2);
        chk("wrap_nofull", 32'(any_full), 32'd0);

        // Randomized traffic: filling bias first, draining bias later, reset midway.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            en               = ($urandom_range(0, 9) != 0);
            din_if.din_valid = ($urandom_range(0, 9) < 7);
            din_if.din       = 8'($urandom);
            clr_ovf          = ($urandom_range(0, 19) == 0);
            if (rd_cnt < wr_cnt && $urandom_range(0, 9) < ((i % 1000) < 600 ? 4 : 9))
                rd_cnt++;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ehgu_fifo_wr_ctrl.md
# ehgu_fifo_wr_ctrl

Write-side front end of the ehgu asynchronous FIFO, living entirely in the wclk domain. It accepts producer data on a valid/ready handshake and drives the write port of the FIFO memory (wenable/waddr/wdata). It keeps the write pointer in binary and Gray form, synchronizes the read-domain Gray pointer into wclk, and derives full, almost_full, fill level and a sticky overflow flag. Its Gray write pointer output feeds the read-side logic across the clock boundary.

## Interface
- WIDTH, 8, data width.
- AWIDTH, 8, memory address width. Pointers are AWIDTH+1 bits.
- DEPTH, 2**AWIDTH, entry count. Must equal 2**AWIDTH. Any other value is a configuration error, flagged by an elaboration-time assertion.
- SYNC_STG_R2W, 2, read-to-write synchronizer flop stages, minimum 2.
- AFULL_THRESH, DEPTH-4, level at or above which almost_full asserts. Legal range 1..DEPTH.
- wclk  in  1  write clock; all logic is on its rising edge.
- wrstn  in  1  reset, asynchronous, active-low.
- en  in  1  block enable; when 0 no write is accepted.
- din_valid  in  1  producer has data.
- din  in  WIDTH  producer data.
- din_ready  out  1  block can accept; equals en && !full (combinational).
- clr_ovf  in  1  one-cycle pulse that clears overflow.
- rptr_gray  in  AWIDTH+1  read pointer, Gray-coded, launched from a register in the rclk domain.
- wenable  out  1  memory write strobe; equals din_valid && din_ready (combinational).
- waddr  out  AWIDTH  memory write address; equals wptr_bin[AWIDTH-1:0].
- wdata  out  WIDTH  equals din.
- wptr_gray  out  AWIDTH+1  registered Gray write pointer, sent to the read side.
- full  out  1  FIFO holds DEPTH entries, as seen from wclk.
- almost_full  out  1  wlevel >= AFULL_THRESH.
- wlevel  out  AWIDTH+1  conservative fill level, 0..DEPTH.
- overflow  out  1  sticky flag: a write was attempted while the FIFO was full.

## Operation
- Accept condition: wenable = din_valid && en && !full. On accept:
  - the memory writes din at waddr in the same wclk edge;
  - wptr_bin <= wptr_bin + 1, modulo 2**(AWIDTH+1);
  - wptr_gray <= gray(wptr_bin + 1), where gray(x) = x ^ (x >> 1).
- Without an accept, wptr_bin and wptr_gray hold.
- Synchronizer: rptr_gray passes through a chain of SYNC_STG_R2W flops; the last stage is rptr_sync. The chain carries no logic between stages.
- rptr_bin_sync = gray2bin(rptr_sync), combinational, computed MSB downward by XOR prefix.
- Level: wlevel = (wptr_bin - rptr_bin_sync) mod 2**(AWIDTH+1), computed from registered values only.
- Flags: full = (wlevel == DEPTH); almost_full = (wlevel >= AFULL_THRESH).
- Overflow is a register:
  - it sets when din_valid && en && full;
  - it clears when clr_ovf;
  - if set and clear occur in the same cycle, set wins;
  - a refused write never changes pointers or memory.
- en = 0: din_ready = 0 and wenable = 0. Pointers, synchronizer and flags keep operating. Overflow is not set while en = 0.
- Wrap-around: the pointer MSB toggles every DEPTH writes. The level arithmetic is modular, so crossing the wrap needs no special case.

## Timing
- Reset values (wrstn low, asynchronous):
  - wptr_bin = 0, wptr_gray = 0, all synchronizer stages = 0, overflow = 0;
  - hence wlevel = 0, full = 0, almost_full = 0 (AFULL_THRESH >= 1), waddr = 0;
  - din_ready = en, wenable = din_valid && en.
- Write latency: the accept at edge N makes the new wptr_gray visible after edge N. wlevel, full and almost_full reflect that write from edge N onward; there is no extra cycle.
- Full release latency: a read-pointer change at the rptr_gray input shows in rptr_sync after SYNC_STG_R2W wclk edges. full and wlevel follow combinationally from that point. The level over-reports during this delay; it never under-reports.
- Back-to-back writes: one per wclk cycle while din_ready = 1.
- Reset mid-operation: pointers return to 0 immediately and any in-flight write is dropped. The system must reset the rclk side in the same reset window; this block does not detect mismatched resets.
- wptr_gray comes straight from a flop, with no combinational path to the output. Only one bit changes per increment.

## Test plan
- Reset with en = 1, din_valid = 0 -> wlevel = 0, full = 0, almost_full = 0, overflow = 0, din_ready = 1, wptr_gray = 0.
- Defaults, rptr_gray held at 0, din_valid = 1 for 260 cycles -> wenable on the first 256 cycles, waddr 0..255, then:
  - full = 1, din_ready = 0, wlevel = 256;
  - almost_full rises on the edge where wlevel reaches 252;
  - overflow = 1 from the 257th cycle;
  - wptr_gray = 9'h180.
- From full, drive rptr_gray = gray(1) = 9'h001 -> full stays 1 for exactly 2 wclk edges, then clears with wlevel = 255. One more write sets full again.
- Wrap: stream 600 writes while rptr_gray tracks wptr_gray with 3-cycle lag -> full never asserts, waddr wraps 255 -> 0 twice, and wptr_gray changes 1 bit per write.
- With en = 0 and din_valid = 1 for 10 cycles -> wenable = 0, pointers unchanged, overflow stays 0.
- clr_ovf pulse while overflow = 1 and no write attempt -> overflow = 0 the next cycle. clr_ovf in the same cycle as a write attempt while full -> overflow remains 1.
